// File: rtl/rx_dma_framer_pkg.sv
// Shared definitions for the RX DMA framer: master command codes, RX word layout, FSM states.
package rx_dma_framer_pkg;

  localparam logic [1:0] MST_ADDR_HI = 2'b10;
  localparam logic [1:0] MST_ADDR_LO = 2'b11;
  localparam logic [1:0] MST_DATA    = 2'b00;
  localparam logic [1:0] MST_LAST    = 2'b01;

  localparam int RX_LAST_BIT = 17;
  localparam int RX_HALF_BIT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRAPCHK,
    S_PAY_ADDR,
    S_PAY_DATA,
    S_DISCARD,
    S_HDR_ADDR,
    S_HDR_DATA,
    S_COMMIT
  } state_t;

endpackage

// File: rtl/rx_skid_reg.sv
// One-entry skid buffer behind a 1-cycle-latency FIFO read; the arriving word bypasses when consumed.
// Reads are only issued when the buffer will be empty next cycle, so mst backpressure never drops a word.
module rx_skid_reg (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        src_empty_i,
  input  logic        want_i,
  output logic        rd_en_o,
  input  logic [17:0] src_dat_i,
  output logic        out_vld_o,
  output logic [17:0] out_dat_o,
  input  logic        out_rdy_i
);

  logic        pend_q;
  logic        vld_q;
  logic        vld_d;
  logic [17:0] dat_q;
  logic [17:0] dat_d;
  logic        pop;

  // pend_q and vld_q are never set together, so occupancy is just out_vld_o
  assign out_vld_o = vld_q | pend_q;
  assign out_dat_o = vld_q ? dat_q : src_dat_i;
  assign pop       = out_vld_o & out_rdy_i;
  assign rd_en_o   = want_i & ~src_empty_i & (~out_vld_o | pop);

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (pend_q && !vld_q && !pop) begin
      vld_d = 1'b1;
      dat_d = src_dat_i;
    end else if (vld_q && pop) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      pend_q <= rd_en_o;
      vld_q  <= vld_d;
      dat_q  <= dat_d;
    end
  end

endmodule

// File: rtl/rx_dma_framer.sv
// Turns RX FIFO frames into DMA write bursts into a host ring: payload first, then a length/flags header.
// One word per cycle when unstalled; mst_full stalls the FSM, with the in-flight RX word held in a skid.
module rx_dma_framer #(
  parameter int MAX_FRAME   = 1536,
  parameter int BURST_WORDS = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [17:0] phy_dout,
  input  logic        phy_empty,
  output logic        phy_rd_en,
  output logic [17:0] mst_din,
  input  logic        mst_full,
  output logic        mst_wr_en,
  input  logic        dma_enable,
  input  logic [19:0] dma_length,
  input  logic [29:0] dma_addr_start,
  output logic [29:0] dma_addr_cur,
  output logic        sys_intr,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);
  import rx_dma_framer_pkg::*;

  localparam logic [15:0] MAX_WORDS = 16'(MAX_FRAME / 2);
  localparam logic [15:0] MAX_BYTES = 16'(MAX_FRAME);
  localparam logic [19:0] WRAP_MIN  = 20'((MAX_FRAME + 4) / 4);
  localparam logic [7:0]  BURST_W   = 8'(BURST_WORDS);
  localparam logic [29:0] BURST_DW  = 30'(BURST_WORDS / 2);

  state_t      state_q, state_d;
  logic [29:0] cur_q, cur_d;
  logic [29:0] hdr_q, hdr_d;
  logic [29:0] pay_q, pay_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [15:0] len_q, len_d;
  logic        trunc_q, trunc_d;
  logic        pad_q, pad_d;
  logic        hi_q, hi_d;
  logic [15:0] fc_q, fc_d;
  logic [15:0] dc_q, dc_d;
  logic        intr_q, intr_d;
  logic        en_q;
  logic        rld_q, rld_d;

  logic        want;
  logic        s_rdy;
  logic        s_vld;
  logic [17:0] s_dat;
  logic        rd_en;
  logic        wr;
  logic [17:0] wdat;
  logic [15:0] wcnt_n;
  logic [7:0]  bcnt_n;
  logic [7:0]  bcnt_up;
  logic [19:0] rem;
  logic [29:0] eff;
  logic [29:0] addr;
  logic        w_last;

  rx_skid_reg u_skid (
    .clk_i       (sys_clk),
    .rst_n_i     (sys_rst_n),
    .src_empty_i (phy_empty | ~sys_rst_n),
    .want_i      (want),
    .rd_en_o     (rd_en),
    .src_dat_i   (phy_dout),
    .out_vld_o   (s_vld),
    .out_dat_o   (s_dat),
    .out_rdy_i   (s_rdy)
  );

  assign phy_rd_en    = rd_en;
  assign mst_wr_en    = wr & sys_rst_n;
  assign mst_din      = wdat;
  assign dma_addr_cur = cur_q;
  assign sys_intr     = intr_q;
  assign frame_count  = fc_q;
  assign drop_count   = dc_q;

  assign wcnt_n  = wcnt_q + 16'd1;
  assign bcnt_n  = bcnt_q + 8'd1;
  assign bcnt_up = bcnt_n + 8'd1;
  assign rem     = dma_addr_start[19:0] + dma_length - cur_q[19:0];
  assign w_last  = s_dat[RX_LAST_BIT];

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hdr_d   = hdr_q;
    pay_d   = pay_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    pad_d   = pad_q;
    hi_d    = hi_q;
    fc_d    = fc_q;
    dc_d    = dc_q;
    intr_d  = 1'b0;
    want    = 1'b0;
    s_rdy   = 1'b0;
    wr      = 1'b0;
    wdat    = '0;
    eff     = cur_q;
    addr    = (state_q == S_PAY_ADDR) ? pay_q : hdr_q;
    // an enable rising edge is remembered until the FSM is back in IDLE
    rld_d   = rld_q | (dma_enable & ~en_q);

    case (state_q)
      S_IDLE: begin
        wcnt_d  = '0;
        bcnt_d  = '0;
        trunc_d = 1'b0;
        pad_d   = 1'b0;
        hi_d    = 1'b0;
        if (rld_d) begin
          cur_d = dma_addr_start;
          rld_d = 1'b0;
        end
        if (s_vld || !phy_empty) state_d = dma_enable ? S_WRAPCHK : S_DISCARD;
      end
      S_WRAPCHK: begin
        eff     = (rem < WRAP_MIN) ? dma_addr_start : cur_q;
        cur_d   = eff;
        hdr_d   = eff;
        pay_d   = eff + 30'd1;
        state_d = S_PAY_ADDR;
      end
      S_PAY_ADDR, S_HDR_ADDR: begin
        if (!mst_full) begin
          wr = 1'b1;
          if (!hi_q) begin
            wdat = {MST_ADDR_HI, addr[29:14]};
            hi_d = 1'b1;
          end else begin
            wdat    = {MST_ADDR_LO, addr[13:0], 2'b00};
            hi_d    = 1'b0;
            state_d = (state_q == S_PAY_ADDR) ? S_PAY_DATA : S_HDR_DATA;
          end
        end
      end
      S_PAY_DATA: begin
        if (pad_q) begin
          if (!mst_full) begin
            wr      = 1'b1;
            wdat    = {MST_LAST, 16'h0000};
            pad_d   = 1'b0;
            state_d = S_HDR_ADDR;
          end
        end else if (trunc_q) begin
          want  = 1'b1;
          s_rdy = 1'b1;
          if (s_vld && w_last) state_d = S_HDR_ADDR;
        end else begin
          want  = 1'b1;
          s_rdy = ~mst_full;
          if (s_vld && !mst_full) begin
            wr     = 1'b1;
            wdat   = {((bcnt_n == BURST_W) || (w_last && !wcnt_n[0])) ? MST_LAST : MST_DATA,
                      s_dat[15:0]};
            wcnt_d = wcnt_n;
            bcnt_d = bcnt_n;
            if (w_last || (wcnt_n == MAX_WORDS)) begin
              // pay_q becomes the dword just past the payload, rounding an odd word count up
              pay_d   = pay_q + {23'h0, bcnt_up[7:1]};
              len_d   = w_last ? ({wcnt_n[14:0], 1'b0} - {15'h0, s_dat[RX_HALF_BIT]}) : MAX_BYTES;
              trunc_d = ~w_last;
              pad_d   = w_last & wcnt_n[0];
              if (w_last && !wcnt_n[0]) state_d = S_HDR_ADDR;
            end else if (bcnt_n == BURST_W) begin
              pay_d   = pay_q + BURST_DW;
              bcnt_d  = '0;
              state_d = S_PAY_ADDR;
            end
          end
        end
      end
      S_HDR_DATA: begin
        if (!mst_full) begin
          wr = 1'b1;
          if (!hi_q) begin
            wdat = {MST_DATA, len_q};
            hi_d = 1'b1;
          end else begin
            wdat    = {MST_LAST, 15'h0, trunc_q};
            hi_d    = 1'b0;
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        cur_d   = pay_q;
        fc_d    = fc_q + 16'd1;
        intr_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_DISCARD: begin
        want  = 1'b1;
        s_rdy = 1'b1;
        if (s_vld && w_last) begin
          dc_d    = dc_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      hdr_q   <= '0;
      pay_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
      pad_q   <= 1'b0;
      hi_q    <= 1'b0;
      fc_q    <= '0;
      dc_q    <= '0;
      intr_q  <= 1'b0;
      en_q    <= 1'b0;
      rld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      hdr_q   <= hdr_d;
      pay_q   <= pay_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
      pad_q   <= pad_d;
      hi_q    <= hi_d;
      fc_q    <= fc_d;
      dc_q    <= dc_d;
      intr_q  <= intr_d;
      en_q    <= dma_enable;
      rld_q   <= rld_d;
    end
  end

endmodule
